// File: rtl/uart_tx.sv
// ============================================================================
// uart_tx : 8-bit UART transmitter, optional parity, 1 or 2 stop bits
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q == IDLE) begin
            if (tx_valid && ready_q) begin
                state_d = START;
                cnt_d   = '0;
                idx_d   = 3'd0;
                shift_d = tx_data;
                par_d   = (^tx_data) ^ (PARITY_ODD != 0);
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        idx_d   = 3'd0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    idx_d   = 3'd0;
                end
                STOP: begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Outputs follow the next state so every output comes straight from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_ready = ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = done_q;

endmodule

`default_nettype wire

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameters, one per line (name, default, meaning); the block SHALL support exactly these:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values are 1 or 2.
REQ-002 Derived constant BIT_PERIOD = CLK_FREQ / BAUD_RATE (integer division); bit counter width SHALL be sized to hold BIT_PERIOD-1.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, system clock; all logic on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- tx_data, input, 8, byte to transmit.
- tx_valid, input, 1, tx_data valid.
- tx_ready, output, 1, block can accept a byte this cycle.
- tx, output, 1, serial line, idle high.
- busy, output, 1, frame in progress.
- tx_done, output, 1, one-cycle pulse at frame end.
REQ-004 Single clock domain (clk); reset asynchronous, active-low (rst_n); all outputs registered.

Function
REQ-005 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-006 Handshake: a byte is accepted only on a cycle where tx_valid=1 and tx_ready=1; tx_ready SHALL be 1 only in IDLE.
REQ-007 On accept: tx_data latched into an internal shift register, and parity computed from the latched byte; FSM enters START; tx SHALL go low on the next clock edge (latency 1 cycle).
REQ-008 Each bit (start, data, parity, stop) SHALL drive tx for exactly BIT_PERIOD clock cycles.
REQ-009 START drives tx=0; DATA sends 8 bits LSB first; PARITY (only if PARITY_EN=1) drives XOR of data bits, inverted when PARITY_ODD=1; STOP drives tx=1 for STOP_BITS bit periods.
REQ-010 Frame length from first low cycle to return to IDLE SHALL be (1+8+PARITY_EN+STOP_BITS)*BIT_PERIOD cycles.
REQ-011 busy SHALL be 1 from the cycle after accept through the last STOP cycle; 0 in IDLE.
REQ-012 tx_done SHALL pulse high for exactly one cycle, the first IDLE cycle after STOP completes, coincident with tx_ready=1.
REQ-013 Back-to-back: if tx_valid is held high, the next byte is accepted in that first IDLE cycle, giving exactly one extra idle-high cycle between frames.
REQ-014 Changes to tx_data or tx_valid while busy=1 SHALL NOT affect the frame in progress.
REQ-015 tx_valid=0 in IDLE: tx stays 1, no state change.

Reset
REQ-016 While rst_n=0: FSM=IDLE, tx=1, tx_ready=0, busy=0, tx_done=0, counters cleared.
REQ-017 tx_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-018 Reset mid-frame SHALL abort immediately: tx=1 asynchronously, no tx_done pulse, partial byte discarded.

Verification
Bench parameters: CLK_FREQ=1600, BAUD_RATE=100 (BIT_PERIOD=16).
REQ-019 Send 0x55, no parity, 1 stop -> tx sequence 0,1,0,1,0,1,0,1,0,1 with 16 cycles per bit; tx_done pulses once at cycle 161 after accept.
REQ-020 Send 0xA3, PARITY_EN=1, PARITY_ODD=0 -> data 1,1,0,0,0,1,0,1, then parity bit 0, then stop 1; frame is 176 cycles.
REQ-021 Send 0x00, PARITY_ODD=1, STOP_BITS=2 -> parity bit 1; stop high for 32 cycles; frame is 192 cycles.
REQ-022 tx_valid held high with bytes 0x01 then 0xFF -> second start bit begins exactly one cycle after tx_done; tx_ready is low throughout each frame.
REQ-023 Assert rst_n=0 during data bit 3 of 0x0F -> tx=1 immediately; busy=0; no tx_done; the next accepted byte 0x81 transmits correctly.
REQ-024 Toggle tx_data and tx_valid randomly while busy=1 -> the transmitted frame equals the originally accepted byte.
